// File: rtl/lsf_lut_reader_pkg.sv
// Shared LSF LUT-reader constants, job/tag payload types and the address saturation helper.
package lsf_lut_reader_pkg;

  localparam int unsigned LUT_ADDR_WIDTH         = 12;
  localparam int unsigned LUT_DEPTH              = 4096;
  localparam int unsigned NUM_READS              = 8;
  localparam int unsigned ROM_LATENCY            = 2;
  localparam int unsigned DATA_WIDTH             = 18;
  localparam int unsigned SF2PTCALC_SEGANGLE_LEN = 10;
  localparam int unsigned ANGLE_WIDTH            = SF2PTCALC_SEGANGLE_LEN;
  localparam int unsigned ROM_INDEX_WIDTH        = 3;
  localparam int unsigned IDX_WIDTH              = $clog2(NUM_READS);
  localparam int unsigned SUM_WIDTH              = LUT_ADDR_WIDTH + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } lut_rd_state_t;

  typedef struct packed {
    logic [LUT_ADDR_WIDTH-1:0]  start;
    logic [ROM_INDEX_WIDTH-1:0] rom_index;
    logic [ANGLE_WIDTH-1:0]     angle;
  } lut_job_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]       idx;
    logic                       first;
    logic                       last;
    logic                       clamped;
    logic [ROM_INDEX_WIDTH-1:0] rom_index;
    logic [ANGLE_WIDTH-1:0]     angle;
  } lut_rd_tag_t;

  // Returns {clamped, address}; the sum carries one extra bit so an overrun is never lost.
  function automatic logic [SUM_WIDTH-1:0] lut_sat_addr(
    input logic [LUT_ADDR_WIDTH-1:0] start,
    input logic [IDX_WIDTH-1:0]      idx
  );
    logic [SUM_WIDTH-1:0] sum;
    sum = SUM_WIDTH'(start) + SUM_WIDTH'(idx);
    if (sum > SUM_WIDTH'(LUT_DEPTH - 1)) begin
      return {1'b1, LUT_ADDR_WIDTH'(LUT_DEPTH - 1)};
    end
    return {1'b0, sum[LUT_ADDR_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/lsf_lut_tag_pipe.sv
// Delay line of read tags; stage 0 lines up with rom_en, the tail with the returning ROM word.
module lsf_lut_tag_pipe
  import lsf_lut_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  input  lut_rd_tag_t in_tag,
  output logic        out_vld,
  output lut_rd_tag_t out_tag
);

  logic [DEPTH-1:0]        vld_q;
  lut_rd_tag_t [DEPTH-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], in_vld};
      tag_q <= {tag_q[DEPTH-2:0], in_tag};
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/lsf_lut_reader.sv
// LUT ROM read sequencer: NUM_READS saturating reads per job, one queued job, tagged framed output.
module lsf_lut_reader
  import lsf_lut_reader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic [LUT_ADDR_WIDTH-1:0]  in_lut_start_addr,
  input  logic [ROM_INDEX_WIDTH-1:0] in_rom_index,
  input  logic [ANGLE_WIDTH-1:0]     in_angle_mrad,
  output logic                       rom_en,
  output logic [LUT_ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  output logic                       out_vld,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [IDX_WIDTH-1:0]       out_idx,
  output logic                       out_first,
  output logic                       out_last,
  output logic                       out_clamped,
  output logic [ROM_INDEX_WIDTH-1:0] out_rom_index,
  output logic [ANGLE_WIDTH-1:0]     out_angle_mrad,
  output logic                       drop,
  output logic                       overflow
);

  lut_rd_state_t            state_q, state_n;
  lut_job_t                 act_q, act_n, pend_q, pend_n, in_job;
  logic [IDX_WIDTH-1:0]     idx_q, idx_n;
  logic                     pend_vld_q, pend_vld_n;
  logic                     drop_n, issue_n, last_rd, clamp_n;
  logic [LUT_ADDR_WIDTH-1:0] addr_n;
  lut_rd_tag_t              tag_n, tail_tag;

  assign in_job  = '{start: in_lut_start_addr, rom_index: in_rom_index, angle: in_angle_mrad};
  assign last_rd = (idx_q == IDX_WIDTH'(NUM_READS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      pend_q     <= '0;
      idx_q      <= '0;
      pend_vld_q <= 1'b0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      drop       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_n;
      act_q      <= act_n;
      pend_q     <= pend_n;
      idx_q      <= idx_n;
      pend_vld_q <= pend_vld_n;
      rom_en     <= issue_n;
      rom_addr   <= issue_n ? addr_n : '0;
      drop       <= drop_n;
      overflow   <= overflow | drop_n;
    end
  end

  // Next job selection; the registered rom_en/rom_addr are computed from the next-state view.
  always_comb begin
    state_n    = state_q;
    act_n      = act_q;
    pend_n     = pend_q;
    idx_n      = idx_q;
    pend_vld_n = pend_vld_q;
    drop_n     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_vld) begin
          act_n   = in_job;
          idx_n   = '0;
          state_n = ST_READ;
        end
      end
      ST_READ: begin
        if (last_rd) begin
          idx_n = '0;
          if (pend_vld_q) begin
            act_n      = pend_q;
            pend_vld_n = in_vld;
            if (in_vld) pend_n = in_job;
          end else if (in_vld) begin
            act_n = in_job;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          idx_n = idx_q + IDX_WIDTH'(1);
          if (in_vld) begin
            if (!pend_vld_q) begin
              pend_vld_n = 1'b1;
              pend_n     = in_job;
            end else begin
              drop_n = 1'b1;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    issue_n           = (state_n == ST_READ);
    {clamp_n, addr_n} = lut_sat_addr(act_n.start, idx_n);
    tag_n = '{idx:       idx_n,
              first:     (idx_n == '0),
              last:      (idx_n == IDX_WIDTH'(NUM_READS - 1)),
              clamped:   clamp_n,
              rom_index: act_n.rom_index,
              angle:     act_n.angle};
  end

  lsf_lut_tag_pipe #(
    .DEPTH(ROM_LATENCY + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (issue_n),
    .in_tag (tag_n),
    .out_vld(out_vld),
    .out_tag(tail_tag)
  );

  // ROM word is forwarded combinationally and held at zero outside valid beats.
  assign out_data       = out_vld ? rom_data : '0;
  assign out_idx        = tail_tag.idx;
  assign out_first      = tail_tag.first;
  assign out_last       = tail_tag.last;
  assign out_clamped    = tail_tag.clamped;
  assign out_rom_index  = tail_tag.rom_index;
  assign out_angle_mrad = tail_tag.angle;

endmodule

// File: tb/tb_lsf_lut_reader.sv
// Directed bench for lsf_lut_reader: single-job vector table plus queued/overflow/reset sequences.
module tb_lsf_lut_reader;
  import lsf_lut_reader_pkg::*;

  localparam int NR = NUM_READS;
  localparam int RL = ROM_LATENCY;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic [11:0] in_lut_start_addr = '0;
  logic [2:0]  in_rom_index = '0;
  logic [9:0]  in_angle_mrad = '0;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [17:0] rom_data;
  logic        out_vld;
  logic [17:0] out_data;
  logic [2:0]  out_idx;
  logic        out_first, out_last, out_clamped;
  logic [2:0]  out_rom_index;
  logic [9:0]  out_angle_mrad;
  logic        drop, overflow;

  lsf_lut_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_vld           (in_vld),
    .in_lut_start_addr(in_lut_start_addr),
    .in_rom_index     (in_rom_index),
    .in_angle_mrad    (in_angle_mrad),
    .rom_en           (rom_en),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .out_vld          (out_vld),
    .out_data         (out_data),
    .out_idx          (out_idx),
    .out_first        (out_first),
    .out_last         (out_last),
    .out_clamped      (out_clamped),
    .out_rom_index    (out_rom_index),
    .out_angle_mrad   (out_angle_mrad),
    .drop             (drop),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Two-cycle ROM; word = {6'h15, address}, all-ones when not enabled.
  logic [17:0] rom_p1 = '1, rom_p2 = '1;
  always @(posedge clk) begin
    rom_p1 <= rom_en ? {6'h15, rom_addr} : '1;
    rom_p2 <= rom_p1;
  end
  assign rom_data = rom_p2;

  typedef struct packed {
    logic [11:0]       start;
    logic [2:0]        ri;
    logic [9:0]        angle;
    logic [0:7][11:0]  addr;
    logic [7:0]        cmask;
  } vec_t;

  typedef struct {
    int               in_cyc;
    int               issue;   // -1: job expected to be dropped
    logic [11:0]      start;
    logic [2:0]       ri;
    logic [9:0]       angle;
    logic [0:7][11:0] addr;
    logic [7:0]       cmask;
  } job_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  job_t jobs[4];
  int   n_jobs;
  vec_t vecs[5];

  task automatic chk(input string seq, input string sig, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s cyc %0d: got 0x%0h expected 0x%0h", seq, sig, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string seq);
    chk(seq, "rom_en", -1, 32'(rom_en), 0);
    chk(seq, "rom_addr", -1, 32'(rom_addr), 0);
    chk(seq, "out_vld", -1, 32'(out_vld), 0);
    chk(seq, "out_data", -1, 32'(out_data), 0);
    chk(seq, "out_idx", -1, 32'(out_idx), 0);
    chk(seq, "out_first", -1, 32'(out_first), 0);
    chk(seq, "out_last", -1, 32'(out_last), 0);
    chk(seq, "out_clamped", -1, 32'(out_clamped), 0);
    chk(seq, "out_rom_index", -1, 32'(out_rom_index), 0);
    chk(seq, "out_angle", -1, 32'(out_angle_mrad), 0);
    chk(seq, "drop", -1, 32'(drop), 0);
    chk(seq, "overflow", -1, 32'(overflow), 0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    in_vld = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic job_t mk_job(input int in_cyc, input int issue, input logic [11:0] start,
                                  input logic [2:0] ri, input logic [9:0] angle);
    job_t j;
    j.in_cyc = in_cyc;
    j.issue  = issue;
    j.start  = start;
    j.ri     = ri;
    j.angle  = angle;
    for (int k = 0; k < NR; k++) j.addr[k] = start + 12'(k);
    j.cmask = 8'h00;
    return j;
  endfunction

  // Drives jobs[0..n_jobs-1] at their input cycles and checks every output each cycle.
  task automatic run_seq(input string seq, input int n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      logic        e_en, e_vld, e_drop, e_ovf;
      logic [11:0] e_addr;
      int          jv, kv;
      in_vld            = 1'b0;
      in_lut_start_addr = 12'hABC;
      in_rom_index      = 3'd6;
      in_angle_mrad     = 10'h155;
      for (int j = 0; j < n_jobs; j++) begin
        if (jobs[j].in_cyc == c) begin
          in_vld            = 1'b1;
          in_lut_start_addr = jobs[j].start;
          in_rom_index      = jobs[j].ri;
          in_angle_mrad     = jobs[j].angle;
        end
      end
      @(negedge clk);
      e_en = 0; e_vld = 0; e_drop = 0; e_ovf = 0; e_addr = '0; jv = 0; kv = 0;
      for (int j = 0; j < n_jobs; j++) begin
        if (jobs[j].issue >= 0) begin
          if (c >= jobs[j].issue && c < jobs[j].issue + NR) begin
            e_en   = 1;
            e_addr = jobs[j].addr[c - jobs[j].issue];
          end
          if (c - jobs[j].issue - RL >= 0 && c - jobs[j].issue - RL < NR) begin
            e_vld = 1;
            jv    = j;
            kv    = c - jobs[j].issue - RL;
          end
        end else begin
          if (c == jobs[j].in_cyc + 1) e_drop = 1;
          if (c >= jobs[j].in_cyc + 1) e_ovf = 1;
        end
      end
      chk(seq, "rom_en", c, 32'(rom_en), 32'(e_en));
      if (e_en) chk(seq, "rom_addr", c, 32'(rom_addr), 32'(e_addr));
      chk(seq, "out_vld", c, 32'(out_vld), 32'(e_vld));
      if (e_vld) begin
        chk(seq, "out_data", c, 32'(out_data), 32'({6'h15, jobs[jv].addr[kv]}));
        chk(seq, "out_idx", c, 32'(out_idx), 32'(kv));
        chk(seq, "out_first", c, 32'(out_first), 32'(kv == 0));
        chk(seq, "out_last", c, 32'(out_last), 32'(kv == NR - 1));
        chk(seq, "out_clamped", c, 32'(out_clamped), 32'(jobs[jv].cmask[kv]));
        chk(seq, "out_rom_index", c, 32'(out_rom_index), 32'(jobs[jv].ri));
        chk(seq, "out_angle", c, 32'(out_angle_mrad), 32'(jobs[jv].angle));
      end
      chk(seq, "drop", c, 32'(drop), 32'(e_drop));
      chk(seq, "overflow", c, 32'(overflow), 32'(e_ovf));
      tick();
    end
    in_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{12'h100, 3'd3, 10'd37,
                {12'h100, 12'h101, 12'h102, 12'h103, 12'h104, 12'h105, 12'h106, 12'h107}, 8'h00};
    vecs[1] = '{12'hFFC, 3'd7, 10'd511,
                {12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 8'hF0};
    vecs[2] = '{12'hFF9, 3'd1, 10'd0,
                {12'hFF9, 12'hFFA, 12'hFFB, 12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF, 12'hFFF}, 8'h80};
    vecs[3] = '{12'h000, 3'd0, 10'd1023,
                {12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007}, 8'h00};
    vecs[4] = '{12'hFFF, 3'd5, 10'd512,
                {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 8'hFE};

    repeat (2) tick();
    chk_all_zero("por");

    for (int v = 0; v < 5; v++) begin
      do_reset();
      n_jobs = 1;
      jobs[0] = mk_job(0, 1, vecs[v].start, vecs[v].ri, vecs[v].angle);
      jobs[0].addr  = vecs[v].addr;
      jobs[0].cmask = vecs[v].cmask;
      run_seq($sformatf("vec%0d", v), 14);
    end

    do_reset();
    n_jobs = 2;
    jobs[0] = mk_job(0, 1, 12'h200, 3'd2, 10'd100);
    jobs[1] = mk_job(3, 9, 12'h300, 3'd4, 10'd5);
    run_seq("b2b", 22);

    do_reset();
    n_jobs = 2;
    jobs[0] = mk_job(0, 1, 12'h500, 3'd1, 10'd11);
    jobs[1] = mk_job(8, 9, 12'h5F0, 3'd3, 10'd22);
    run_seq("direct", 22);

    do_reset();
    n_jobs = 3;
    jobs[0] = mk_job(0, 1, 12'h600, 3'd1, 10'd70);
    jobs[1] = mk_job(2, 9, 12'h700, 3'd2, 10'd80);
    jobs[2] = mk_job(4, -1, 12'h800, 3'd3, 10'd90);
    run_seq("ovf", 24);

    do_reset();
    n_jobs = 3;
    jobs[0] = mk_job(0, 1, 12'h900, 3'd5, 10'd300);
    jobs[1] = mk_job(2, 9, 12'hA00, 3'd6, 10'd301);
    jobs[2] = mk_job(8, 17, 12'hB00, 3'd7, 10'd302);
    run_seq("simul", 30);

    // Reset in the middle of a job: outputs clear at once, nothing emerges after release.
    do_reset();
    in_vld = 1'b1; in_lut_start_addr = 12'h400; in_rom_index = 3'd2; in_angle_mrad = 10'd44;
    tick();
    in_vld = 1'b0;
    repeat (4) tick();
    chk("rst_mid", "rom_en_before", 5, 32'(rom_en), 1);
    chk("rst_mid", "out_vld_before", 5, 32'(out_vld), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_async");
    repeat (2) tick();
    @(negedge clk);
    chk_all_zero("rst_mid_hold");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_after", "out_vld", c, 32'(out_vld), 0);
      chk("rst_after", "rom_en", c, 32'(rom_en), 0);
      chk("rst_after", "out_data", c, 32'(out_data), 0);
      tick();
    end
    n_jobs = 1;
    jobs[0] = mk_job(0, 1, 12'hC00, 3'd1, 10'd9);
    run_seq("post_rst", 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
